// File: rtl/delay_sweep_controller.sv
// Delay-element sweep controller.
// Holds a static delay code per channel. On command it either requests a
// random re-draw, or sweeps every channel through the codes no/min/typ/max/
// random, dwelling D cycles on each. While on the random code it also
// re-requests a draw every RESEED dwell cycles.
module delay_sweep_controller #(
    parameter int NUM_CH  = 4,
    parameter int DWELL_W = 16,
    parameter int RESEED  = 8
) (
    input  logic                                           clk,
    input  logic                                           reset_n,
    input  logic                                           cfg_valid,
    output logic                                           cfg_ready,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] cfg_ch,
    input  logic [2:0]                                     cfg_type,
    output logic                                           cfg_error,
    input  logic                                           start,
    input  logic                                           stop,
    input  logic                                           sweep_mode,
    input  logic [DWELL_W-1:0]                             dwell_cycles,
    output logic [3*NUM_CH-1:0]                            delay_type_out,
    output logic                                           new_values,
    output logic                                           busy,
    output logic                                           sweep_done,
    output logic [2:0]                                     phase
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int RS_W = $clog2(RESEED + 1);

    localparam logic [RS_W-1:0]    RS_ONE = RS_W'(32'd1);
    localparam logic [RS_W-1:0]    RS_MAX = RS_W'(RESEED);
    localparam logic [DWELL_W-1:0] D_ONE  = DWELL_W'(32'd1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_APPLY   = 3'd1;
    localparam logic [2:0] S_DWELL   = 3'd2;
    localparam logic [2:0] S_ADVANCE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]          state_r, state_next_s;
    logic [2:0]          phase_r, phase_next_s;
    logic [3*NUM_CH-1:0] static_r, static_next_s;
    logic [3*NUM_CH-1:0] dto_r, dto_next_s;
    logic [DWELL_W-1:0]  dwell_len_r, dwell_len_next_s;
    logic [DWELL_W-1:0]  dwell_cnt_r, dwell_cnt_next_s;
    logic [RS_W-1:0]     reseed_cnt_r, reseed_cnt_next_s;
    logic                new_values_r, nv_next_s;
    logic                done_r, done_next_s;
    logic                err_r, err_next_s;
    logic                busy_r, cfg_ready_r;
    logic                run_en_r;
    logic                cfg_fire_s;
    logic [2:0]          cfg_code_s;
    logic                in_sweep_next_s;

    assign delay_type_out = dto_r;
    assign new_values     = new_values_r;
    assign busy           = busy_r;
    assign sweep_done     = done_r;
    assign cfg_error      = err_r;
    assign cfg_ready      = cfg_ready_r;
    assign phase          = phase_r;

    // Reset release synchroniser: commands are honoured from the second edge after release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_en_r <= 1'b0;
        end else begin
            run_en_r <= 1'b1;
        end
    end

    // Next-state, static-register write and output computation.
    always_comb begin
        state_next_s      = state_r;
        phase_next_s      = phase_r;
        dwell_len_next_s  = dwell_len_r;
        dwell_cnt_next_s  = dwell_cnt_r;
        reseed_cnt_next_s = reseed_cnt_r;
        nv_next_s         = new_values_r;
        done_next_s       = 1'b0;

        // Static configuration write; illegal codes are stored as "no delay".
        cfg_fire_s = cfg_valid && cfg_ready_r;
        cfg_code_s = (cfg_type > 3'd4) ? 3'd0 : cfg_type;
        err_next_s = cfg_fire_s && (cfg_type > 3'd4);
        for (int k = 0; k < NUM_CH; k++) begin
            static_next_s[3*k +: 3] = (cfg_fire_s && (cfg_ch == k[CH_W-1:0])) ?
                                      cfg_code_s : static_r[3*k +: 3];
        end

        case (state_r)
            S_IDLE: begin
                if (start && !stop && run_en_r) begin
                    nv_next_s = ~new_values_r;
                    if (sweep_mode) begin
                        state_next_s     = S_APPLY;
                        phase_next_s     = 3'd0;
                        dwell_len_next_s = (dwell_cycles == '0) ? D_ONE : dwell_cycles;
                    end else begin
                        state_next_s = S_IDLE;
                    end
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_APPLY: begin
                if (stop) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s      = S_DWELL;
                    dwell_cnt_next_s  = D_ONE;
                    reseed_cnt_next_s = RS_ONE;
                    nv_next_s = ((phase_r == 3'd4) && (RS_ONE == RS_MAX)) ?
                                ~new_values_r : new_values_r;
                end
            end
            S_DWELL: begin
                if (stop) begin
                    state_next_s = S_IDLE;
                end else if (dwell_cnt_r == dwell_len_r) begin
                    state_next_s = S_ADVANCE;
                end else begin
                    state_next_s      = S_DWELL;
                    dwell_cnt_next_s  = dwell_cnt_r + D_ONE;
                    reseed_cnt_next_s = (reseed_cnt_r == RS_MAX) ? RS_ONE : reseed_cnt_r + RS_ONE;
                    nv_next_s = ((phase_r == 3'd4) && (reseed_cnt_next_s == RS_MAX)) ?
                                ~new_values_r : new_values_r;
                end
            end
            S_ADVANCE: begin
                if (stop) begin
                    state_next_s = S_IDLE;
                end else if (phase_r < 3'd4) begin
                    state_next_s = S_APPLY;
                    phase_next_s = phase_r + 3'd1;
                    nv_next_s    = ~new_values_r;
                end else begin
                    state_next_s = S_DONE;
                    done_next_s  = 1'b1;
                end
            end
            S_DONE: begin
                state_next_s = S_IDLE;
            end
            default: begin
                state_next_s = S_IDLE;
            end
        endcase

        // Channels follow the sweep code from APPLY through ADVANCE, otherwise the static codes.
        in_sweep_next_s = (state_next_s == S_APPLY) || (state_next_s == S_DWELL) ||
                          (state_next_s == S_ADVANCE);
        dto_next_s = in_sweep_next_s ? {NUM_CH{phase_next_s}} : static_next_s;
    end

    // State, static registers and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= S_IDLE;
            phase_r      <= 3'd0;
            static_r     <= '0;
            dto_r        <= '0;
            dwell_len_r  <= D_ONE;
            dwell_cnt_r  <= '0;
            reseed_cnt_r <= '0;
            new_values_r <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
            busy_r       <= 1'b0;
            cfg_ready_r  <= 1'b1;
        end else begin
            state_r      <= state_next_s;
            phase_r      <= phase_next_s;
            static_r     <= static_next_s;
            dto_r        <= dto_next_s;
            dwell_len_r  <= dwell_len_next_s;
            dwell_cnt_r  <= dwell_cnt_next_s;
            reseed_cnt_r <= reseed_cnt_next_s;
            new_values_r <= nv_next_s;
            done_r       <= done_next_s;
            err_r        <= err_next_s;
            busy_r       <= (state_next_s != S_IDLE);
            cfg_ready_r  <= (state_next_s == S_IDLE);
        end
    end

endmodule

// File: tb/tb_delay_sweep_controller.sv
// Self-checking bench for delay_sweep_controller. Expected behaviour is
// derived from the sweep timeline: each phase p occupies D+2 cycles
// (APPLY, D dwell cycles, ADVANCE), DONE follows after five phases.
module tb_delay_sweep_controller;

    localparam int NUM_CH  = 4;
    localparam int DWELL_W = 16;
    localparam int RESEED  = 8;

    logic                  clk = 1'b0;
    logic                  reset_n = 1'b1;
    logic                  cfg_valid = 1'b0;
    logic                  cfg_ready;
    logic [1:0]            cfg_ch = 2'd0;
    logic [2:0]            cfg_type = 3'd0;
    logic                  cfg_error;
    logic                  start = 1'b0;
    logic                  stop = 1'b0;
    logic                  sweep_mode = 1'b0;
    logic [DWELL_W-1:0]    dwell_cycles = '0;
    logic [3*NUM_CH-1:0]   delay_type_out;
    logic                  new_values;
    logic                  busy;
    logic                  sweep_done;
    logic [2:0]            phase;

    int   checks = 0;
    int   errors = 0;
    int   exp_static[NUM_CH];
    logic exp_nv = 1'b0;

    delay_sweep_controller #(.NUM_CH(NUM_CH), .DWELL_W(DWELL_W), .RESEED(RESEED)) dut (
        .clk(clk), .reset_n(reset_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_ch(cfg_ch), .cfg_type(cfg_type), .cfg_error(cfg_error),
        .start(start), .stop(stop), .sweep_mode(sweep_mode), .dwell_cycles(dwell_cycles),
        .delay_type_out(delay_type_out), .new_values(new_values), .busy(busy),
        .sweep_done(sweep_done), .phase(phase)
    );

    always #5 clk = ~clk;

    function automatic logic [3*NUM_CH-1:0] static_word();
        logic [3*NUM_CH-1:0] w;
        for (int k = 0; k < NUM_CH; k++) w[3*k +: 3] = exp_static[k][2:0];
        return w;
    endfunction

    function automatic logic [3*NUM_CH-1:0] phase_word(input int p);
        logic [3*NUM_CH-1:0] w;
        for (int k = 0; k < NUM_CH; k++) w[3*k +: 3] = p[2:0];
        return w;
    endfunction

    task automatic release_reset();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    // Drives one sweep and checks every cycle against the timeline.
    // abort_kind: 0 none, 1 stop after step abort_step, 2 reset after step abort_step.
    // cfg_mode: 0 none, 1 write together with start, 2 write held during the sweep.
    task automatic run_sweep(input int d, input int abort_kind, input int abort_step,
                             input int cfg_mode, input bit noisy);
        int deff, per, last, p, r, toggles, wch, wty;
        logic prev_nv;
        logic [3*NUM_CH-1:0] e_dto;
        logic e_busy, e_done, e_ready;
        deff = (d == 0) ? 1 : d;
        per  = deff + 2;
        last = 5 * per + 1;
        toggles = 0;
        prev_nv = new_values;
        wch = $urandom_range(0, NUM_CH - 1);
        wty = $urandom_range(0, 7);
        start = 1'b1; stop = 1'b0; sweep_mode = 1'b1; dwell_cycles = DWELL_W'(d);
        if (cfg_mode == 1) begin
            cfg_valid = 1'b1; cfg_ch = wch[1:0]; cfg_type = wty[2:0];
        end
        @(negedge clk);
        start = 1'b0;
        if (cfg_mode == 1) begin
            cfg_valid = 1'b0;
            exp_static[wch] = (wty > 4) ? 0 : wty;
        end
        if (cfg_mode == 2) begin
            cfg_valid = 1'b1; cfg_ch = wch[1:0]; cfg_type = wty[2:0];
        end
        for (int s = 0; s <= last; s++) begin
            p = s / per;
            r = s % per;
            if (s < 5 * per) begin
                if (r == 0) exp_nv = ~exp_nv;
                if (p == 4 && r >= 1 && r <= deff && (r % RESEED) == 0) exp_nv = ~exp_nv;
                e_dto = phase_word(p); e_busy = 1'b1; e_done = 1'b0; e_ready = 1'b0;
                checks++;
                if (phase !== p[2:0]) begin
                    errors++; $display("FAIL phase d=%0d s=%0d got %0d want %0d", d, s, phase, p);
                end
            end else if (s == 5 * per) begin
                e_dto = static_word(); e_busy = 1'b1; e_done = 1'b1; e_ready = 1'b0;
            end else begin
                e_dto = static_word(); e_busy = 1'b0; e_done = 1'b0; e_ready = 1'b1;
            end
            if (new_values !== prev_nv) toggles++;
            prev_nv = new_values;
            checks++;
            if (delay_type_out !== e_dto) begin
                errors++; $display("FAIL sweep_dto d=%0d s=%0d got %h want %h", d, s, delay_type_out, e_dto);
            end
            checks++;
            if (busy !== e_busy) begin
                errors++; $display("FAIL sweep_busy d=%0d s=%0d got %b want %b", d, s, busy, e_busy);
            end
            checks++;
            if (sweep_done !== e_done) begin
                errors++; $display("FAIL sweep_done d=%0d s=%0d got %b want %b", d, s, sweep_done, e_done);
            end
            checks++;
            if (cfg_ready !== e_ready) begin
                errors++; $display("FAIL sweep_ready d=%0d s=%0d got %b want %b", d, s, cfg_ready, e_ready);
            end
            checks++;
            if (new_values !== exp_nv) begin
                errors++; $display("FAIL sweep_nv d=%0d s=%0d got %b want %b", d, s, new_values, exp_nv);
            end
            if (abort_kind == 1 && s == abort_step) begin
                stop = 1'b1;
                @(negedge clk);
                stop = 1'b0;
                return;
            end
            if (abort_kind == 2 && s == abort_step) begin
                #2 reset_n = 1'b0;
                return;
            end
            if (s < last) begin
                if (noisy) begin
                    start = 1'($urandom_range(0, 1));
                    sweep_mode = 1'($urandom_range(0, 1));
                    dwell_cycles = DWELL_W'($urandom_range(0, 40));
                end
                @(negedge clk);
            end
        end
        start = 1'b0;
        checks++;
        if (toggles != 5 + deff / RESEED) begin
            errors++; $display("FAIL toggle_count d=%0d got %0d want %0d", d, toggles, 5 + deff / RESEED);
        end
        if (cfg_mode == 2) begin
            @(negedge clk);
            cfg_valid = 1'b0;
            exp_static[wch] = (wty > 4) ? 0 : wty;
            checks++;
            if (delay_type_out !== static_word()) begin
                errors++; $display("FAIL held_cfg_dto got %h want %h", delay_type_out, static_word());
            end
            checks++;
            if (cfg_error !== (wty > 4)) begin
                errors++; $display("FAIL held_cfg_err got %b want %b", cfg_error, (wty > 4));
            end
        end
    endtask

    task automatic test_reset();
        #2 reset_n = 1'b0;
        #1;
        for (int k = 0; k < NUM_CH; k++) exp_static[k] = 0;
        exp_nv = 1'b0;
        checks++;
        if (delay_type_out !== '0) begin errors++; $display("FAIL rst_dto got %h want 0", delay_type_out); end
        checks++;
        if (phase !== 3'd0) begin errors++; $display("FAIL rst_phase got %0d want 0", phase); end
        checks++;
        if (new_values !== 1'b0) begin errors++; $display("FAIL rst_nv got %b want 0", new_values); end
        checks++;
        if (busy !== 1'b0 || sweep_done !== 1'b0 || cfg_error !== 1'b0) begin
            errors++; $display("FAIL rst_flags got %b%b%b want 000", busy, sweep_done, cfg_error);
        end
        checks++;
        if (cfg_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", cfg_ready); end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        start = 1'b1; sweep_mode = 1'b0;
        @(negedge clk);
        checks++;
        if (new_values !== 1'b0) begin errors++; $display("FAIL rst_first_edge got %b want 0", new_values); end
        @(negedge clk);
        start = 1'b0;
        exp_nv = 1'b1;
        checks++;
        if (new_values !== 1'b1) begin errors++; $display("FAIL rst_second_edge got %b want 1", new_values); end
    endtask

    task automatic test_cfg();
        int ch, ty;
        for (int i = 0; i < 14; i++) begin
            if (i == 0) begin ch = 2; ty = 3; end
            else if (i == 1) begin ch = 0; ty = 7; end
            else begin ch = $urandom_range(0, NUM_CH - 1); ty = $urandom_range(0, 7); end
            cfg_valid = 1'b1; cfg_ch = ch[1:0]; cfg_type = ty[2:0];
            @(negedge clk);
            cfg_valid = 1'b0;
            exp_static[ch] = (ty > 4) ? 0 : ty;
            checks++;
            if (delay_type_out !== static_word()) begin
                errors++; $display("FAIL cfg_dto i=%0d got %h want %h", i, delay_type_out, static_word());
            end
            checks++;
            if (cfg_error !== (ty > 4)) begin
                errors++; $display("FAIL cfg_err i=%0d got %b want %b", i, cfg_error, (ty > 4));
            end
            if (i == 1) begin
                checks++;
                if (delay_type_out !== 12'h0C0) begin
                    errors++; $display("FAIL cfg_example got %h want 0c0", delay_type_out);
                end
                @(negedge clk);
                checks++;
                if (cfg_error !== 1'b0) begin errors++; $display("FAIL cfg_err_pulse got %b want 0", cfg_error); end
            end
        end
    endtask

    task automatic test_reseed_only();
        for (int i = 0; i < 4; i++) begin
            start = 1'b1; stop = 1'b0; sweep_mode = 1'b0;
            @(negedge clk);
            start = 1'b0;
            exp_nv = ~exp_nv;
            checks++;
            if (new_values !== exp_nv || busy !== 1'b0) begin
                errors++; $display("FAIL reseed_only i=%0d got nv=%b busy=%b want nv=%b busy=0", i, new_values, busy, exp_nv);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic test_start_with_stop();
        for (int m = 0; m < 2; m++) begin
            start = 1'b1; stop = 1'b1; sweep_mode = m[0]; dwell_cycles = 16'd3;
            @(negedge clk);
            start = 1'b0; stop = 1'b0;
            checks++;
            if (busy !== 1'b0 || new_values !== exp_nv) begin
                errors++; $display("FAIL start_stop m=%0d got busy=%b nv=%b want busy=0 nv=%b", m, busy, new_values, exp_nv);
            end
        end
    endtask

    task automatic test_sweep();
        run_sweep(3, 0, 0, 0, 1'b0);
        run_sweep(16, 0, 0, 0, 1'b0);
        run_sweep(0, 0, 0, 0, 1'b0);
    endtask

    task automatic test_stop();
        run_sweep(3, 1, 2 * 5 + 2, 0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (busy !== 1'b0 || sweep_done !== 1'b0 || cfg_ready !== 1'b1) begin
                errors++; $display("FAIL stop_flags i=%0d got busy=%b done=%b ready=%b want 0 0 1", i, busy, sweep_done, cfg_ready);
            end
            checks++;
            if (delay_type_out !== static_word() || new_values !== exp_nv) begin
                errors++; $display("FAIL stop_outputs i=%0d got %h/%b want %h/%b", i, delay_type_out, new_values, static_word(), exp_nv);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_cfg_with_sweep();
        run_sweep(2, 0, 0, 2, 1'b0);
        run_sweep(4, 0, 0, 1, 1'b0);
    endtask

    task automatic test_random_sweeps();
        for (int i = 0; i < 3; i++) begin
            run_sweep($urandom_range(0, 12), 0, 0, 0, 1'b1);
            sweep_mode = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_sweep();
        run_sweep(2, 2, 3 * 4 + 2, 0, 1'b0);
        #1;
        for (int k = 0; k < NUM_CH; k++) exp_static[k] = 0;
        exp_nv = 1'b0;
        checks++;
        if (delay_type_out !== '0 || phase !== 3'd0 || new_values !== 1'b0) begin
            errors++; $display("FAIL midrst_outputs got %h/%0d/%b want 0/0/0", delay_type_out, phase, new_values);
        end
        checks++;
        if (busy !== 1'b0 || sweep_done !== 1'b0 || cfg_ready !== 1'b1 || cfg_error !== 1'b0) begin
            errors++; $display("FAIL midrst_flags got %b%b%b%b want 0010", busy, sweep_done, cfg_ready, cfg_error);
        end
        release_reset();
        run_sweep(2, 0, 0, 0, 1'b0);
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_cfg();
        test_reseed_only();
        test_start_with_stop();
        test_sweep();
        test_stop();
        test_cfg_with_sweep();
        test_random_sweeps();
        test_reset_mid_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
